instr_decode_stage: RTL and testbench



---
 rtl/instr_decode_pkg.sv | 80 ++++++++
 rtl/instr_decode_comb.sv | 124 ++++++++++++
 rtl/instr_decode_stage.sv | 121 ++++++++++++
 tb/tb_instr_decode_stage.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_decode_pkg.sv
// Shared decode constants: opcodes, funct fields, ALU operation codes,
// format encoding and instruction field positions.
package instr_decode_pkg;

    localparam logic [6:0] OPC_LUI     = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC   = 7'b0010111;
    localparam logic [6:0] OPC_JAL     = 7'b1101111;
    localparam logic [6:0] OPC_JALR    = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH  = 7'b1100011;
    localparam logic [6:0] OPC_LOAD    = 7'b0000011;
    localparam logic [6:0] OPC_STORE   = 7'b0100011;
    localparam logic [6:0] OPC_ALU_IMM = 7'b0010011;
    localparam logic [6:0] OPC_ALU_REG = 7'b0110011;

    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLL     = 3'b001;
    localparam logic [2:0] F3_SLT     = 3'b010;
    localparam logic [2:0] F3_SLTU    = 3'b011;
    localparam logic [2:0] F3_XOR     = 3'b100;
    localparam logic [2:0] F3_SRL_SRA = 3'b101;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_AND     = 3'b111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    localparam int ALU_FUNCT_WIDTH = 4;

    typedef enum logic [ALU_FUNCT_WIDTH-1:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLT  = 4'd5,
        ALU_SLTU = 4'd6,
        ALU_SLL  = 4'd7,
        ALU_SRL  = 4'd8,
        ALU_SRA  = 4'd9
    } alu_funct_e;

    typedef enum logic [2:0] {
        FMT_R = 3'd0,
        FMT_I = 3'd1,
        FMT_S = 3'd2,
        FMT_B = 3'd3,
        FMT_U = 3'd4,
        FMT_J = 3'd5
    } fmt_e;

    localparam int OPC_LSB = 0;
    localparam int OPC_MSB = 6;
    localparam int RD_LSB  = 7;
    localparam int RD_MSB  = 11;
    localparam int F3_LSB  = 12;
    localparam int F3_MSB  = 14;
    localparam int RS1_LSB = 15;
    localparam int RS1_MSB = 19;
    localparam int RS2_LSB = 20;
    localparam int RS2_MSB = 24;
    localparam int F7_LSB  = 25;
    localparam int F7_MSB  = 31;

    // alt selects the SUB/SRA variant of funct3 000/101
    function automatic alu_funct_e alu_map(input logic [2:0] funct3, input logic alt);
        alu_funct_e res;
        case (funct3)
            F3_ADD_SUB: res = alt ? ALU_SUB : ALU_ADD;
            F3_SLL:     res = ALU_SLL;
            F3_SLT:     res = ALU_SLT;
            F3_SLTU:    res = ALU_SLTU;
            F3_XOR:     res = ALU_XOR;
            F3_SRL_SRA: res = alt ? ALU_SRA : ALU_SRL;
            F3_OR:      res = ALU_OR;
            default:    res = ALU_AND;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/instr_decode_comb.sv
// Pure combinational decode of one RV32I word into operation, operands,
// immediate, format and illegal flag.
module instr_decode_comb
    import instr_decode_pkg::*;
#(
    parameter int XLEN           = 32,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic [31:0]                instr_i,
    input  logic                       control_override_i,
    output logic [ALU_FUNCT_WIDTH-1:0] alu_funct_o,
    output logic [REG_ADDR_WIDTH-1:0]  rs1_o,
    output logic [REG_ADDR_WIDTH-1:0]  rs2_o,
    output logic [REG_ADDR_WIDTH-1:0]  rd_o,
    output logic                       rs1_used_o,
    output logic                       rs2_used_o,
    output logic                       rd_write_o,
    output logic [XLEN-1:0]            immed_o,
    output logic [2:0]                 fmt_o,
    output logic                       illegal_o
);

    logic [6:0]        opcode;
    logic [2:0]        funct3;
    logic [6:0]        funct7;
    logic signed [31:0] imm32;
    alu_funct_e        alu;
    fmt_e              fmt;
    logic              illegal;
    logic              wr;

    assign opcode = instr_i[OPC_MSB:OPC_LSB];
    assign funct3 = instr_i[F3_MSB:F3_LSB];
    assign funct7 = instr_i[F7_MSB:F7_LSB];

    // Opcode/funct decode, immediate assembly and operand qualifiers
    always_comb begin
        imm32      = '0;
        fmt        = FMT_R;
        illegal    = 1'b0;
        alu        = ALU_ADD;
        rs1_used_o = 1'b1;
        rs2_used_o = 1'b1;
        wr         = 1'b1;
        case (opcode)
            OPC_LUI, OPC_AUIPC: begin
                fmt   = FMT_U;
                imm32 = {instr_i[31:12], 12'b0};
            end
            OPC_JAL: begin
                fmt   = FMT_J;
                imm32 = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20],
                         instr_i[30:21], 1'b0};
            end
            OPC_JALR, OPC_LOAD: begin
                fmt   = FMT_I;
                imm32 = {{20{instr_i[31]}}, instr_i[31:20]};
            end
            OPC_STORE: begin
                fmt   = FMT_S;
                imm32 = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
            end
            OPC_BRANCH: begin
                fmt   = FMT_B;
                imm32 = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25],
                         instr_i[11:8], 1'b0};
            end
            OPC_ALU_IMM: begin
                fmt = FMT_I;
                if (funct3 == F3_SLL || funct3 == F3_SRL_SRA) begin
                    // shift amount is unsigned; bit 24 is not a sign bit here
                    imm32 = {27'b0, instr_i[24:20]};
                end else begin
                    imm32 = {{20{instr_i[31]}}, instr_i[31:20]};
                end
                if (funct3 == F3_SLL) begin
                    illegal = (funct7 != F7_BASE);
                end else if (funct3 == F3_SRL_SRA) begin
                    illegal = (funct7 != F7_BASE) && (funct7 != F7_ALT);
                end
                // funct7 is immediate data for ADDI, so only SRAI uses it
                alu = alu_map(funct3, (funct3 == F3_SRL_SRA) && (funct7 == F7_ALT));
            end
            OPC_ALU_REG: begin
                fmt     = FMT_R;
                illegal = !((funct7 == F7_BASE) ||
                            ((funct7 == F7_ALT) &&
                             (funct3 == F3_ADD_SUB || funct3 == F3_SRL_SRA)));
                alu     = alu_map(funct3, funct7 == F7_ALT);
            end
            default: begin
                illegal = 1'b1;
            end
        endcase

        if (control_override_i || illegal) begin
            alu = ALU_ADD;
        end

        case (fmt)
            FMT_I:        rs2_used_o = 1'b0;
            FMT_S, FMT_B: wr = 1'b0;
            FMT_U, FMT_J: begin
                rs1_used_o = 1'b0;
                rs2_used_o = 1'b0;
            end
            default: ;
        endcase

        if (illegal) begin
            wr = 1'b0;
        end
    end

    assign alu_funct_o = alu;
    assign fmt_o       = fmt;
    assign illegal_o   = illegal;
    assign rd_write_o  = wr;
    assign immed_o     = XLEN'(imm32);
    assign rs1_o       = REG_ADDR_WIDTH'(instr_i[RS1_MSB:RS1_LSB]);
    assign rs2_o       = REG_ADDR_WIDTH'(instr_i[RS2_MSB:RS2_LSB]);
    assign rd_o        = wr ? REG_ADDR_WIDTH'(instr_i[RD_MSB:RD_LSB]) : '0;

endmodule

// File: rtl/instr_decode_stage.sv
// Decode stage between fetch and execute: combinational decode feeding a
// one-entry valid/ready output register with flush and an illegal counter.
module instr_decode_stage
    import instr_decode_pkg::*;
#(
    parameter int XLEN           = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       in_valid_i,
    output logic                       in_ready_o,
    input  logic [31:0]                instr_i,
    input  logic                       control_override_i,
    input  logic                       flush_i,
    output logic                       out_valid_o,
    input  logic                       out_ready_i,
    output logic [ALU_FUNCT_WIDTH-1:0] alu_funct_o,
    output logic [REG_ADDR_WIDTH-1:0]  rs1_o,
    output logic [REG_ADDR_WIDTH-1:0]  rs2_o,
    output logic [REG_ADDR_WIDTH-1:0]  rd_o,
    output logic                       rs1_used_o,
    output logic                       rs2_used_o,
    output logic                       rd_write_o,
    output logic [XLEN-1:0]            immed_o,
    output logic [2:0]                 fmt_o,
    output logic                       illegal_o,
    output logic [CNT_WIDTH-1:0]       illegal_count_o
);

    logic [ALU_FUNCT_WIDTH-1:0] dec_alu;
    logic [REG_ADDR_WIDTH-1:0]  dec_rs1, dec_rs2, dec_rd;
    logic                       dec_rs1_used, dec_rs2_used, dec_rd_write, dec_illegal;
    logic [XLEN-1:0]            dec_immed;
    logic [2:0]                 dec_fmt;

    logic                       out_valid_q, out_valid_d;
    logic [CNT_WIDTH-1:0]       cnt_q, cnt_d;
    logic                       load;

    instr_decode_comb #(
        .XLEN           (XLEN),
        .REG_ADDR_WIDTH (REG_ADDR_WIDTH)
    ) u_dec (
        .instr_i            (instr_i),
        .control_override_i (control_override_i),
        .alu_funct_o        (dec_alu),
        .rs1_o              (dec_rs1),
        .rs2_o              (dec_rs2),
        .rd_o               (dec_rd),
        .rs1_used_o         (dec_rs1_used),
        .rs2_used_o         (dec_rs2_used),
        .rd_write_o         (dec_rd_write),
        .immed_o            (dec_immed),
        .fmt_o              (dec_fmt),
        .illegal_o          (dec_illegal)
    );

    // flush frees the slot, so the stage reports ready during a flush
    assign in_ready_o = !out_valid_q || out_ready_i || flush_i;
    assign load       = in_valid_i && in_ready_o && !flush_i;

    // Next valid and saturating illegal count; flush outranks everything
    always_comb begin
        out_valid_d = out_valid_q;
        cnt_d       = cnt_q;
        if (flush_i) begin
            out_valid_d = 1'b0;
        end else if (load) begin
            out_valid_d = 1'b1;
        end else if (out_ready_i) begin
            out_valid_d = 1'b0;
        end
        if (load && dec_illegal && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Valid flag and counter registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            out_valid_q <= 1'b0;
            cnt_q       <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            cnt_q       <= cnt_d;
        end
    end

    // Decoded payload, captured only on accept so it holds through a stall
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            alu_funct_o <= '0;
            rs1_o       <= '0;
            rs2_o       <= '0;
            rd_o        <= '0;
            rs1_used_o  <= 1'b0;
            rs2_used_o  <= 1'b0;
            rd_write_o  <= 1'b0;
            immed_o     <= '0;
            fmt_o       <= '0;
            illegal_o   <= 1'b0;
        end else if (load) begin
            alu_funct_o <= dec_alu;
            rs1_o       <= dec_rs1;
            rs2_o       <= dec_rs2;
            rd_o        <= dec_rd;
            rs1_used_o  <= dec_rs1_used;
            rs2_used_o  <= dec_rs2_used;
            rd_write_o  <= dec_rd_write;
            immed_o     <= dec_immed;
            fmt_o       <= dec_fmt;
            illegal_o   <= dec_illegal;
        end
    end

    assign out_valid_o     = out_valid_q;
    assign illegal_count_o = cnt_q;

endmodule

// File: tb/tb_instr_decode_stage.sv
module tb_instr_decode_stage;

    localparam int CW = 4;
    localparam logic [CW-1:0] CNT_MAX = '1;

    // expected encodings of ALU operations and formats
    localparam logic [3:0] A_ADD = 4'd0, A_SUB = 4'd1, A_AND = 4'd2, A_OR = 4'd3,
                           A_XOR = 4'd4, A_SLT = 4'd5, A_SLTU = 4'd6, A_SLL = 4'd7,
                           A_SRL = 4'd8, A_SRA = 4'd9;
    localparam logic [2:0] F_R = 3'd0, F_I = 3'd1, F_S = 3'd2, F_B = 3'd3,
                           F_U = 3'd4, F_J = 3'd5;

    typedef struct packed {
        logic [3:0]  alu;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        u1;
        logic        u2;
        logic        wr;
        logic [31:0] imm;
        logic [2:0]  fmt;
        logic        ill;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [31:0]   instr = '0;
    logic          ovr = 1'b0;
    logic          flush = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [3:0]    alu_funct;
    logic [4:0]    rs1, rs2, rd;
    logic          rs1_used, rs2_used, rd_write;
    logic [31:0]   immed;
    logic [2:0]    fmt;
    logic          illegal;
    logic [CW-1:0] illegal_count;

    exp_t          q[$];
    int            model_cnt = 0;
    int            n_cmp = 0;
    int            n_bad = 0;

    always #5 clk = ~clk;

    instr_decode_stage #(
        .XLEN           (32),
        .REG_ADDR_WIDTH (5),
        .CNT_WIDTH      (CW)
    ) dut (
        .clk_i              (clk),
        .rst_i              (rst),
        .in_valid_i         (in_valid),
        .in_ready_o         (in_ready),
        .instr_i            (instr),
        .control_override_i (ovr),
        .flush_i            (flush),
        .out_valid_o        (out_valid),
        .out_ready_i        (out_ready),
        .alu_funct_o        (alu_funct),
        .rs1_o              (rs1),
        .rs2_o              (rs2),
        .rd_o               (rd),
        .rs1_used_o         (rs1_used),
        .rs2_used_o         (rs2_used),
        .rd_write_o         (rd_write),
        .immed_o            (immed),
        .fmt_o              (fmt),
        .illegal_o          (illegal),
        .illegal_count_o    (illegal_count)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference decoder: works from the instruction-set rules with integer arithmetic
    function automatic exp_t ref_decode(input logic [31:0] w, input logic override);
        exp_t e;
        logic [6:0] op;
        logic [2:0] f3;
        logic [6:0] f7;
        int v;
        logic [3:0] base_ops [8];
        logic [2:0] use_tab  [6];
        base_ops = '{A_ADD, A_SLL, A_SLT, A_SLTU, A_XOR, A_SRL, A_OR, A_AND};
        // {rs1_used, rs2_used, rd_write} indexed by format
        use_tab  = '{3'b111, 3'b101, 3'b110, 3'b110, 3'b001, 3'b001};
        op = w[6:0];
        f3 = w[14:12];
        f7 = w[31:25];
        e = '0;
        e.alu = A_ADD;
        e.rs1 = w[19:15];
        e.rs2 = w[24:20];
        e.fmt = F_R;
        v = int'(w[31:20]);
        if (v >= 2048) v -= 4096;
        case (op)
            7'h37, 7'h17: begin
                e.fmt = F_U;
                e.imm = w & 32'hFFFF_F000;
            end
            7'h6F: begin
                e.fmt = F_J;
                v = int'({w[31], w[19:12], w[20], w[30:21], 1'b0});
                if (v >= (1 << 20)) v -= (1 << 21);
                e.imm = 32'(v);
            end
            7'h67, 7'h03: begin
                e.fmt = F_I;
                e.imm = 32'(v);
            end
            7'h23: begin
                e.fmt = F_S;
                v = int'({w[31:25], w[11:7]});
                if (v >= 2048) v -= 4096;
                e.imm = 32'(v);
            end
            7'h63: begin
                e.fmt = F_B;
                v = int'({w[31], w[7], w[30:25], w[11:8], 1'b0});
                if (v >= 4096) v -= 8192;
                e.imm = 32'(v);
            end
            7'h13: begin
                e.fmt = F_I;
                if (f3 == 3'd1 || f3 == 3'd5) e.imm = 32'(w[24:20]);
                else                          e.imm = 32'(v);
                e.ill = (f3 == 3'd1 && f7 != 7'h00) ||
                        (f3 == 3'd5 && f7 != 7'h00 && f7 != 7'h20);
                e.alu = (f3 == 3'd5 && f7 == 7'h20) ? A_SRA : base_ops[f3];
            end
            7'h33: begin
                e.fmt = F_R;
                e.ill = !(f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)));
                e.alu = base_ops[f3];
                if (f7 == 7'h20 && f3 == 3'd0) e.alu = A_SUB;
                if (f7 == 7'h20 && f3 == 3'd5) e.alu = A_SRA;
            end
            default: e.ill = 1'b1;
        endcase
        if (override || e.ill) e.alu = A_ADD;
        {e.u1, e.u2, e.wr} = use_tab[e.fmt];
        if (e.ill) e.wr = 1'b0;
        e.rd = e.wr ? w[11:7] : 5'd0;
        return e;
    endfunction

    // Hand-written expectation; register fields come straight from the word
    function automatic exp_t mk(input logic [31:0] w, input logic [3:0] a, input logic [31:0] imm,
                                input logic [2:0] f, input logic [2:0] uses, input logic ill);
        exp_t e;
        e.alu = a;
        e.rs1 = w[19:15];
        e.rs2 = w[24:20];
        {e.u1, e.u2, e.wr} = uses;
        e.rd  = e.wr ? w[11:7] : 5'd0;
        e.imm = imm;
        e.fmt = f;
        e.ill = ill;
        return e;
    endfunction

    // One cycle of stimulus; the expectation is queued if the model says it is accepted
    task automatic cyc(input logic v, input logic [31:0] w, input logic o, input logic ordy,
                       input logic fl, input bit lit, input exp_t le);
        exp_t e;
        @(posedge clk);
        #1;
        in_valid  = v;
        instr     = w;
        ovr       = o;
        out_ready = ordy;
        flush     = fl;
        @(negedge clk);
        #1;
        if (v && !fl && q.size() == 0) begin
            e = lit ? le : ref_decode(w, o);
            q.push_back(e);
            if (e.ill && model_cnt < int'(CNT_MAX)) model_cnt++;
        end
    endtask

    task automatic run(input logic [31:0] w, input logic ordy);
        cyc(1'b1, w, 1'b0, ordy, 1'b0, 1'b0, '0);
    endtask

    task automatic idle();
        cyc(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, '0);
    endtask

    task automatic check_reset_state();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_count", illegal_count, 0);
        chk("rst_data", {alu_funct, rs1, rs2, rd, rs1_used, rs2_used, rd_write, immed, fmt, illegal}, 0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #3;
        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b1;
        rst       = 1'b1;
        #1;
        check_reset_state();
        q.delete();
        model_cnt = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    function automatic logic [31:0] rand_instr();
        logic [6:0] ops [9];
        logic [31:0] w;
        int k;
        ops = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33};
        w = $urandom;
        k = $urandom_range(0, 10);
        if (k < 9) w[6:0] = ops[k];
        if ((w[6:0] == 7'h13 || w[6:0] == 7'h33) && ($urandom_range(0, 3) != 0))
            w[31:25] = $urandom_range(0, 1) ? 7'h20 : 7'h00;
        return w;
    endfunction

    // Monitor: checks handshake and count every cycle, payload against the queue head
    always @(negedge clk) begin
        if (!rst) begin
            chk("out_valid", out_valid, q.size() != 0);
            chk("in_ready", in_ready, (q.size() == 0) || out_ready || flush);
            chk("illegal_count", illegal_count, model_cnt);
            if (out_valid && q.size() != 0) begin
                chk("alu_funct", alu_funct, q[0].alu);
                chk("rs1", rs1, q[0].rs1);
                chk("rs2", rs2, q[0].rs2);
                chk("rd", rd, q[0].rd);
                chk("uses", {rs1_used, rs2_used, rd_write}, {q[0].u1, q[0].u2, q[0].wr});
                chk("immed", immed, q[0].imm);
                chk("fmt", fmt, q[0].fmt);
                chk("illegal", illegal, q[0].ill);
            end
            if (flush) q.delete();
            else if (out_ready && q.size() != 0) void'(q.pop_front());
        end
    end

    initial begin
        exp_t nul;
        nul = '0;
        #2;
        check_reset_state();
        @(posedge clk);
        #1;
        rst = 1'b0;

        // addi x1,x2,-1 and srai x3,x4,31
        cyc(1, 32'hFFF10093, 0, 1, 0, 1, mk(32'hFFF10093, A_ADD, 32'hFFFF_FFFF, F_I, 3'b101, 0));
        cyc(1, 32'h41F25193, 0, 1, 0, 1, mk(32'h41F25193, A_SRA, 32'h0000_001F, F_I, 3'b101, 0));
        // back-to-back sw -4, beq -0x800, lui, jal -4
        cyc(1, 32'hFE532E23, 0, 1, 0, 1, mk(32'hFE532E23, A_ADD, 32'hFFFF_FFFC, F_S, 3'b110, 0));
        cyc(1, 32'h802080E3, 0, 1, 0, 1, mk(32'h802080E3, A_ADD, 32'hFFFF_F800, F_B, 3'b110, 0));
        cyc(1, 32'hABCDE3B7, 0, 1, 0, 1, mk(32'hABCDE3B7, A_ADD, 32'hABCD_E000, F_U, 3'b001, 0));
        cyc(1, 32'hFFDFF0EF, 0, 1, 0, 1, mk(32'hFFDFF0EF, A_ADD, 32'hFFFF_FFFC, F_J, 3'b001, 0));
        // sub with override forced to ADD
        cyc(1, 32'h40310233, 1, 1, 0, 1, mk(32'h40310233, A_ADD, 32'h0, F_R, 3'b111, 0));

        // stall three cycles with the next word held on the input
        run(32'h00A37293, 1);
        run(32'h0062D233, 0);
        run(32'h0062D233, 0);
        run(32'h0062D233, 0);
        run(32'h0062D233, 1);
        idle();

        // illegal opcode, then ALU_REG funct7 0x01
        cyc(1, 32'h0000007F, 0, 1, 0, 1, mk(32'h0000007F, A_ADD, 32'h0, F_R, 3'b110, 1));
        cyc(1, 32'h023100B3, 0, 1, 0, 1, mk(32'h023100B3, A_ADD, 32'h0, F_R, 3'b110, 1));
        idle();

        // flush while holding, with an illegal word offered in the same cycle
        run(32'h00500113, 0);
        run(32'h00100193, 0);
        cyc(1, 32'h0000007F, 0, 0, 1, 0, nul);
        idle();
        idle();

        for (int i = 0; i < 600; i++) begin
            cyc($urandom_range(0, 3) != 0, rand_instr(), $urandom_range(0, 7) == 0,
                $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0, 0, nul);
        end

        // enough illegal accepts to pin the counter at all-ones
        for (int i = 0; i < 20; i++) begin
            run({$urandom_range(0, 32'h01FF_FFFF), 7'h7F}, 1);
        end
        idle();

        // reset in the middle of a stall
        run(32'h00C00293, 0);
        run(32'h00D00313, 0);
        do_reset();
        idle();
        for (int i = 0; i < 40; i++) begin
            cyc($urandom_range(0, 1) != 0, rand_instr(), 1'b0,
                $urandom_range(0, 2) != 0, 1'b0, 0, nul);
        end
        idle();
        idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
